// File: rtl/bus_arbiter.sv
// Two-master / one-slave Wishbone-style arbiter with alternating tie priority.
// Optional stalled-strobe bus-error timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          i_cyc_i,
   input  logic          i_stb_i,
   input  logic [AW-1:0] i_adr_i,
   output logic [DW-1:0] i_dat_o,
   output logic          i_ack_o,
   output logic          i_err_o,

   input  logic          d_cyc_i,
   input  logic          d_stb_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_adr_i,
   input  logic [DW-1:0] d_dat_i,
   output logic [DW-1:0] d_dat_o,
   output logic          d_ack_o,
   output logic          d_err_o,

   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,

   output logic [1:0]    gnt_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   pri_i_q, pri_i_d;
   logic   stb_req;
   logic   to_hit;
   logic   ack_fwd;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pri_i_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pri_i_q <= pri_i_d;
      end
   end

   // Releasing a tenure always passes through IDLE, giving one dead cycle.
   always_comb begin
      state_d = state_q;
      pri_i_d = pri_i_q;
      case (state_q)
         IDLE: begin
            if (i_cyc_i && (!d_cyc_i || pri_i_q))
               state_d = GNT_I;
            else if (d_cyc_i)
               state_d = GNT_D;
         end
         GNT_I: begin
            if (!i_cyc_i) begin
               state_d = IDLE;
               pri_i_d = 1'b0;
            end
         end
         GNT_D: begin
            if (!d_cyc_i) begin
               state_d = IDLE;
               pri_i_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stb_req = (state_q == GNT_I) ? i_stb_i :
                    (state_q == GNT_D) ? d_stb_i : 1'b0;

   always_comb begin
      gnt_o   = 2'b00;
      s_cyc_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      i_dat_o = '0;
      d_dat_o = '0;
      case (state_q)
         GNT_I: begin
            gnt_o   = 2'b01;
            s_cyc_o = i_cyc_i;
            s_adr_o = i_adr_i;
            i_dat_o = s_dat_i;
         end
         GNT_D: begin
            gnt_o   = 2'b10;
            s_cyc_o = d_cyc_i;
            s_we_o  = d_we_i;
            s_adr_o = d_adr_i;
            s_dat_o = d_dat_i;
            d_dat_o = s_dat_i;
         end
         default: ;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0] to_q, to_d;

   // The TIMEOUT-th consecutive stalled cycle is the one that fires, so the
   // compare is against the count already accumulated before this cycle.
   assign to_hit = stb_req && !s_ack_i && (to_q == CW'(TIMEOUT - 1));

   always_comb begin
      to_d = to_q + 1'b1;
      if (!stb_req || s_ack_i || to_hit || (state_d != state_q))
         to_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_q <= '0;
      else
         to_q <= to_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   assign s_stb_o = stb_req && !to_hit;
   assign ack_fwd = s_stb_o && s_ack_i;
   assign i_ack_o = ack_fwd && (state_q == GNT_I);
   assign d_ack_o = ack_fwd && (state_q == GNT_D);
   assign i_err_o = to_hit && (state_q == GNT_I);
   assign d_err_o = to_hit && (state_q == GNT_D);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter; timeout expectations follow ARB_TIMEOUT_EN.
module tb_bus_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam logic [AW-1:0] I_ADR = 16'h0010;
   localparam logic [AW-1:0] D_ADR = 16'h0200;
   localparam logic [DW-1:0] D_DAT = 32'hCAFE0001;
   localparam logic [DW-1:0] S_DAT = 32'hDEADBEEF;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk, rst;
   logic          i_cyc_i, i_stb_i, i_ack_o, i_err_o;
   logic [AW-1:0] i_adr_i;
   logic [DW-1:0] i_dat_o;
   logic          d_cyc_i, d_stb_i, d_we_i, d_ack_o, d_err_o;
   logic [AW-1:0] d_adr_i;
   logic [DW-1:0] d_dat_i, d_dat_o;
   logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o, s_dat_i;
   logic [1:0]    gnt_o;

   int n_chk  = 0;
   int n_fail = 0;

   bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_adr_i(i_adr_i),
      .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
      .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
      .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_dat_o(d_dat_o),
      .d_ack_o(d_ack_o), .d_err_o(d_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .gnt_o(gnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ic, is, dc, ds, dwe, ack;
      logic [1:0] gnt;
      logic       scyc, sstb, swe, iack, dack;
   } vec_t;

   vec_t tbl [33];

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [127:0] exp_data(input logic [1:0] g);
      logic [AW-1:0] a;
      logic [DW-1:0] so, id, dd;
      a  = (g == 2'b01) ? I_ADR : (g == 2'b10) ? D_ADR : '0;
      so = (g == 2'b10) ? D_DAT : '0;
      id = (g == 2'b01) ? S_DAT : '0;
      dd = (g == 2'b10) ? S_DAT : '0;
      return {16'h0, a, so, id, dd};
   endfunction

   function automatic logic [127:0] act_data();
      return {16'h0, s_adr_o, s_dat_o, i_dat_o, d_dat_o};
   endfunction

   initial begin
      //         ic is dc ds we ack  gnt    cyc stb we iack dack
      tbl = '{
         '{1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 0  instr request in IDLE
         '{1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0},   // 1  granted next cycle
         '{1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0},   // 2
         '{1, 1, 0, 0, 0, 1, 2'b01, 1, 1, 0, 1, 0},   // 3  ack -> instr
         '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0},   // 4  cyc dropped
         '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 5
         '{1, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0},   // 6  tie, pri=0
         '{1, 1, 1, 1, 1, 1, 2'b10, 1, 1, 1, 0, 1},   // 7  data wins
         '{1, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0},   // 8  data releases
         '{1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 9  dead cycle
         '{1, 1, 0, 0, 0, 1, 2'b01, 1, 1, 0, 1, 0},   // 10 instr granted
         '{0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0},   // 11
         '{1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 12 alternation
         '{1, 1, 1, 1, 0, 1, 2'b10, 1, 1, 0, 0, 1},   // 13
         '{1, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0},   // 14
         '{1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 15
         '{1, 1, 1, 1, 0, 1, 2'b01, 1, 1, 0, 1, 0},   // 16
         '{0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0},   // 17
         '{1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 18
         '{1, 1, 1, 1, 0, 1, 2'b10, 1, 1, 0, 0, 1},   // 19
         '{1, 1, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0},   // 20
         '{1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 21
         '{1, 1, 1, 1, 0, 1, 2'b01, 1, 1, 0, 1, 0},   // 22
         '{0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0},   // 23
         '{1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0},   // 24 multi-strobe tenure
         '{1, 1, 0, 0, 0, 1, 2'b01, 1, 1, 0, 1, 0},   // 25 strobe 1
         '{1, 0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0},   // 26 data arrives
         '{1, 1, 1, 1, 1, 1, 2'b01, 1, 1, 0, 1, 0},   // 27 strobe 2, we masked
         '{1, 0, 1, 1, 0, 1, 2'b01, 1, 0, 0, 0, 0},   // 28 ack without stb ignored
         '{1, 1, 1, 1, 0, 1, 2'b01, 1, 1, 0, 1, 0},   // 29 strobe 3
         '{0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0},   // 30
         '{0, 0, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0},   // 31
         '{0, 0, 1, 1, 1, 0, 2'b10, 1, 1, 1, 0, 0}    // 32 data holds bus
      };

      i_adr_i = I_ADR;  d_adr_i = D_ADR;  d_dat_i = D_DAT;  s_dat_i = S_DAT;

      // Reset held with every request and ack active.
      rst = 1'b0;
      i_cyc_i = 1'b1; i_stb_i = 1'b1; d_cyc_i = 1'b1; d_stb_i = 1'b1;
      d_we_i = 1'b1;  s_ack_i = 1'b1;
      #12;
      chk("reset ctl", {gnt_o, s_cyc_o, s_stb_o, s_we_o, i_ack_o, d_ack_o, i_err_o, d_err_o}, '0);
      chk("reset data", act_data(), '0);

      @(negedge clk);
      i_cyc_i = 1'b0; i_stb_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
      d_we_i = 1'b0;  s_ack_i = 1'b0;
      rst = 1'b1;

      for (int r = 0; r < 33; r++) begin
         @(negedge clk);
         i_cyc_i = tbl[r].ic;  i_stb_i = tbl[r].is;
         d_cyc_i = tbl[r].dc;  d_stb_i = tbl[r].ds;
         d_we_i  = tbl[r].dwe; s_ack_i = tbl[r].ack;
         #1;
         chk($sformatf("row%0d ctl", r),
             {gnt_o, s_cyc_o, s_stb_o, s_we_o, i_ack_o, d_ack_o, i_err_o, d_err_o},
             {tbl[r].gnt, tbl[r].scyc, tbl[r].sstb, tbl[r].swe, tbl[r].iack, tbl[r].dack, 2'b00});
         chk($sformatf("row%0d data", r), act_data(), exp_data(tbl[r].gnt));
      end

      // Asynchronous reset in the middle of a data tenure.
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async rst", {gnt_o, s_cyc_o, s_stb_o, s_we_o}, 5'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post-rst idle", {gnt_o, s_cyc_o, s_stb_o}, 4'b0);

      // Stalled strobe: data re-granted, slave never acks.
      for (int k = 1; k <= 16; k++) begin
         logic e;
         @(negedge clk);
         #1;
         e = TO_EN && (k == 15);
         chk($sformatf("stall%0d", k),
             {gnt_o, s_cyc_o, s_stb_o, d_err_o, d_ack_o, i_err_o},
             {2'b10, 1'b1, !e, e, 1'b0, 1'b0});
      end

      @(negedge clk);
      d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0;
      #1;
      chk("release", {gnt_o, s_cyc_o, s_stb_o}, {2'b10, 2'b00});
      @(negedge clk);
      #1;
      chk("final idle", {gnt_o, s_cyc_o, s_stb_o}, 4'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave Wishbone-style arbiter that shares the single memory port between the control unit's instruction-fetch master and its data-access master.
- Sits between the control unit and the memory/port slave.
- Grants whole bus cycles (for as long as cyc stays high), routes strobes, addresses and data to the slave, and routes ack/data back only to the granted master.
- Alternates priority on contention so instruction fetch cannot be starved by back-to-back data cycles.

Parameters:
- AW, 16, address width of both masters and the slave
- DW, 32, data width
- TIMEOUT, 15, cycles of unacknowledged strobe before a bus error is forced (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_cyc_i  in  1  instruction master cycle request
- i_stb_i  in  1  instruction master strobe
- i_adr_i  in  AW  instruction address
- i_dat_o  out  DW  read data to instruction master
- i_ack_o  out  1  acknowledge to instruction master
- i_err_o  out  1  bus error to instruction master
- d_cyc_i  in  1  data master cycle request
- d_stb_i  in  1  data master strobe
- d_we_i  in  1  data master write enable
- d_adr_i  in  AW  data address
- d_dat_i  in  DW  write data from data master
- d_dat_o  out  DW  read data to data master
- d_ack_o  out  1  acknowledge to data master
- d_err_o  out  1  bus error to data master
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_we_o  out  1  slave write enable (always 0 when the instruction master is granted)
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  current grant, one-hot: 01 = instruction, 10 = data, 00 = none

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. All state is registered.
- Priority flag pri_i: 1 = instruction wins a tie.
- Reset (rst=0, asynchronous, also mid-cycle):
  - state=IDLE, pri_i=0, gnt_o=00.
  - s_cyc_o, s_stb_o, s_we_o, i_ack_o, d_ack_o, i_err_o, d_err_o are all 0 immediately.
  - s_adr_o, s_dat_o, i_dat_o, d_dat_o are 0.
- IDLE transitions, evaluated at the clock edge:
  - d_cyc_i only -> GNT_D.
  - i_cyc_i only -> GNT_I.
  - Both requesting -> GNT_I if pri_i=1, else GNT_D.
  - Neither -> stay in IDLE.
- Arbitration latency: one cycle. A request seen in IDLE at edge N makes gnt_o and s_cyc_o valid after edge N.
- While in a grant state:
  - s_cyc_o = granted cyc.
  - s_stb_o = granted stb.
  - s_adr_o, s_we_o, s_dat_o follow the granted master combinationally.
- Ack and read-data routing:
  - s_ack_i goes only to the granted master's ack.
  - s_dat_i goes to the granted master's dat_o; the other master's dat_o is 0.
  - The non-granted master sees ack=0 and simply waits.
- Grant release:
  - A grant is held until the granted master drops cyc. Multiple strobes inside one cyc are one tenure.
  - When the granted cyc drops -> IDLE; there is always one dead IDLE cycle between tenures.
  - pri_i is updated on release: leaving GNT_D sets pri_i=1; leaving GNT_I clears pri_i=0.
- No preemption: a higher-priority request never interrupts an active tenure.
- Ack arriving while s_stb_o=0 is ignored and is not forwarded.
- Outside grant states: s_cyc_o=0, s_stb_o=0, s_we_o=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT+1) increments each cycle s_stb_o=1 && s_ack_i=0, and clears on ack, on stb low, or on a grant change.
  - When the counter reaches TIMEOUT:
    - The granted master's err is pulsed high for exactly one cycle, and ack stays 0.
    - s_stb_o is forced low that cycle.
    - The counter clears.
  - The master must then drop cyc or restrobe.
  - Reset clears the counter.
- Undefined: no counter is present; i_err_o=d_err_o=0 constantly, and a stalled slave holds the bus indefinitely.

Test Plan:
- Reset release, then i_cyc_i=i_stb_i=1, i_adr_i=0x0010, s_ack_i=1 after 2 cycles, s_dat_i=0xDEADBEEF -> gnt_o=01 one cycle after request; i_ack_o=1 with i_dat_o=0xDEADBEEF; d_ack_o=0; s_we_o=0.
- Both request in the same cycle from reset -> data granted first (gnt_o=10). After d_cyc_i drops: one IDLE cycle, then gnt_o=01.
- Data master requests continuously with 4 single-ack cycles, instruction requesting throughout -> grants alternate 10,01,10,01; instruction never waits more than one data tenure.
- Instruction tenure of 3 strobes under one cyc while d_cyc_i rises mid-tenure -> gnt_o stays 01 until i_cyc_i drops; d_ack_o=0 throughout.
- rst driven low while gnt_o=10 and s_stb_o=1 -> s_cyc_o, s_stb_o, gnt_o go 0 without waiting for clk. After release with d_cyc_i still high: re-grant to data one cycle later.
- With ARB_TIMEOUT_EN and TIMEOUT=15, strobe with s_ack_i held 0 -> d_err_o=1 for one cycle on the 15th stalled cycle, s_stb_o=0 that cycle. Without the macro: no err, bus held.
